// File: rtl/lcd_responder.sv
// Panel-side HD44780 responder: decodes the 4-bit LCD bus coming from the driver
// and keeps a 2x16 DDRAM shadow image that can be read back by character index.
module lcd_responder #(
  parameter int E_MIN_HIGH = 8,
  parameter int CMD_BUSY   = 1500,
  parameter int CLEAR_BUSY = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:8] SF_D,
  input  logic        LCD_E,
  input  logic        LCD_RS,
  input  logic        LCD_RW,
  input  logic [4:0]  rd_index,
  output logic [7:0]  rd_char,
  output logic [6:0]  ddram_addr,
  output logic        four_bit,
  output logic        display_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        increment,
  output logic        busy,
  output logic        timing_err,
  output logic        proto_err
);

  localparam int BUSY_MAX = (CLEAR_BUSY > CMD_BUSY) ? CLEAR_BUSY : CMD_BUSY;
  localparam int BW = $clog2(BUSY_MAX + 1);
  localparam int HW = $clog2(E_MIN_HIGH + 1);
  localparam logic [BW-1:0] CMD_LOAD   = BW'(CMD_BUSY);
  localparam logic [BW-1:0] CLEAR_LOAD = BW'(CLEAR_BUSY);
  localparam logic [HW-1:0] HIGH_SAT   = HW'(E_MIN_HIGH);

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, HI, LO} state_t;

  state_t         state;
  logic           e_q;
  logic [3:0]     nib_q;
  logic           rs_q;
  logic           rw_q;
  logic [HW-1:0]  high_cnt;
  logic [3:0]     hi_nib;
  logic           hi_rs;
  logic [BW-1:0]  busy_cnt;
  logic           sweeping;
  logic [4:0]     sweep_idx;
  logic [7:0]     ddram [32];

  logic           fall;
  logic           short_pulse;
  logic           wr_strobe;
  logic           accept;
  logic           in_init;
  logic           init_ok;
  logic           exec_byte;
  logic           wr_data;
  logic           load_cmd;
  logic           load_clear;
  logic [7:0]     cmd;
  logic [4:0]     wr_index;

  // Address counter walks the two 16-character lines as one 32-position ring.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] n;
    if (up)
      n = (a[3:0] == 4'hF) ? {~a[6], 6'h00} : a + 7'd1;
    else
      n = (a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : a - 7'd1;
    return n;
  endfunction

  assign fall        = e_q & ~LCD_E;
  assign short_pulse = fall & (high_cnt < HIGH_SAT);
  assign wr_strobe   = fall & ~rw_q;
  assign busy        = (busy_cnt != '0);
  assign accept      = wr_strobe & ~busy;
  assign in_init     = (state == INIT0) || (state == INIT1) ||
                       (state == INIT2) || (state == INIT3);
  assign init_ok     = (nib_q == ((state == INIT3) ? 4'h2 : 4'h3));
  assign cmd         = {hi_nib, nib_q};
  assign exec_byte   = accept & (state == LO);
  assign wr_data     = exec_byte & hi_rs;
  assign load_clear  = exec_byte & ~hi_rs & (cmd == 8'h01);
  assign load_cmd    = (accept & in_init & init_ok) |
                       (exec_byte & (hi_rs | (cmd > 8'h01)));
  assign wr_index    = {ddram_addr[6], ddram_addr[3:0]};
  assign rd_char     = ddram[rd_index];

  // Bus values are captured every high cycle so the falling edge sees the last ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= 1'b0;
      nib_q    <= 4'h0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      high_cnt <= '0;
    end else begin
      e_q <= LCD_E;
      if (LCD_E) begin
        nib_q <= SF_D;
        rs_q  <= LCD_RS;
        rw_q  <= LCD_RW;
        if (high_cnt < HIGH_SAT)
          high_cnt <= high_cnt + HW'(1);
      end else begin
        high_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (load_clear) begin
      busy_cnt <= CLEAR_LOAD;
    end else if (load_cmd) begin
      busy_cnt <= CMD_LOAD;
    end else if (busy) begin
      busy_cnt <= busy_cnt - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT0;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      four_bit   <= 1'b0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      increment  <= 1'b1;
      ddram_addr <= 7'h00;
      timing_err <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (short_pulse || (wr_strobe && busy))
        timing_err <= 1'b1;
      if (accept && in_init && !init_ok)
        proto_err <= 1'b1;
      if (accept) begin
        case (state)
          INIT0: state <= init_ok ? INIT1 : INIT0;
          INIT1: state <= init_ok ? INIT2 : INIT0;
          INIT2: state <= init_ok ? INIT3 : INIT0;
          INIT3: begin
            state    <= init_ok ? HI : INIT0;
            four_bit <= init_ok;
          end
          HI: begin
            hi_nib <= nib_q;
            hi_rs  <= rs_q;
            state  <= LO;
          end
          LO: begin
            state <= HI;
            // A byte whose halves disagree on RS is still executed with the first RS.
            if (rs_q != hi_rs)
              proto_err <= 1'b1;
            if (hi_rs) begin
              ddram_addr <= step_addr(ddram_addr, increment);
            end else begin
              casez (cmd)
                8'b1???????: begin
                  if (cmd[5:4] == 2'b00)
                    ddram_addr <= cmd[6:0];
                  else
                    proto_err <= 1'b1;
                end
                8'b00001???: begin
                  display_on <= cmd[2];
                  cursor_on  <= cmd[1];
                  blink_on   <= cmd[0];
                end
                8'b000001??: increment  <= cmd[1];
                8'b0000001?: ddram_addr <= 7'h00;
                8'b00000001: begin
                  ddram_addr <= 7'h00;
                  increment  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: state <= INIT0;
        endcase
      end
    end
  end

  // Clear blanks one entry per cycle while the panel reports busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        ddram[i] <= 8'h20;
      sweeping  <= 1'b0;
      sweep_idx <= 5'd0;
    end else begin
      if (sweeping) begin
        ddram[sweep_idx] <= 8'h20;
        sweep_idx        <= sweep_idx + 5'd1;
        if (sweep_idx == 5'd31)
          sweeping <= 1'b0;
      end
      if (load_clear) begin
        sweeping  <= 1'b1;
        sweep_idx <= 5'd0;
      end
      if (wr_data)
        ddram[wr_index] <= cmd;
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: table of directed byte vectors, hand-written corner
// sequences, and randomized bus traffic compared with a behavioural panel model.
module tb_lcd_responder;

  localparam int E_MIN = 8;
  localparam int CMD   = 200;
  localparam int CLR   = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:8] SF_D = 4'h0;
  logic        LCD_E = 1'b0;
  logic        LCD_RS = 1'b0;
  logic        LCD_RW = 1'b0;
  logic [4:0]  rd_index = 5'd0;
  logic [7:0]  rd_char;
  logic [6:0]  ddram_addr;
  logic        four_bit, display_on, cursor_on, blink_on, increment;
  logic        busy, timing_err, proto_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lcd_responder #(.E_MIN_HIGH(E_MIN), .CMD_BUSY(CMD), .CLEAR_BUSY(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .rd_index(rd_index), .rd_char(rd_char),
    .ddram_addr(ddram_addr), .four_bit(four_bit), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .increment(increment),
    .busy(busy), .timing_err(timing_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Panel model: position 0..31 on a ring, busy tracked as the last busy edge number.
  logic [7:0] m_mem [32];
  int         m_pos, m_init_step, m_busy_end;
  bit         m_inc, m_disp, m_cur, m_blink, m_four, m_terr, m_perr;
  bit         m_have_hi, m_hi_rs;
  logic [3:0] m_hi;

  typedef struct {
    bit         rs;
    logic [7:0] b;
    logic [6:0] exp_addr;
    bit         exp_disp, exp_cur, exp_blink, exp_inc;
    int         chk_idx;
    logic [7:0] chk_char;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rs, input logic [7:0] b, input logic [6:0] a,
                              input bit d, input bit c, input bit k, input bit inc,
                              input int idx, input logic [7:0] ch);
    vec_t v;
    v.rs = rs; v.b = b; v.exp_addr = a;
    v.exp_disp = d; v.exp_cur = c; v.exp_blink = k; v.exp_inc = inc;
    v.chk_idx = idx; v.chk_char = ch;
    return v;
  endfunction

  function automatic int m_addr();
    return (m_pos < 16) ? m_pos : 64 + m_pos - 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_pos = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0;
    m_four = 0; m_terr = 0; m_perr = 0; m_have_hi = 0; m_hi_rs = 0;
    m_hi = 4'h0; m_init_step = 0; m_busy_end = 0;
  endtask

  task automatic model_byte(input bit rs, input logic [7:0] b, input int j);
    int msb;
    int a;
    if (rs) begin
      m_mem[m_pos] = b;
      m_pos = m_inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
      m_busy_end = j + CMD;
      return;
    end
    msb = -1;
    for (int k = 7; k >= 0; k--)
      if (b[k] && msb < 0) msb = k;
    if (msb < 0) return;
    m_busy_end = j + ((b == 8'h01) ? CLR : CMD);
    case (msb)
      7: begin
        a = int'(b[6:0]);
        if (a < 16) m_pos = a;
        else if (a >= 64 && a < 80) m_pos = a - 64 + 16;
        else m_perr = 1;
      end
      3: begin m_disp = b[2]; m_cur = b[1]; m_blink = b[0]; end
      2: m_inc = b[1];
      1: m_pos = 0;
      0: begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_pos = 0; m_inc = 1;
      end
      default: ;
    endcase
  endtask

  task automatic model_strobe(input logic [3:0] n, input bit rs, input bit rw,
                              input int high, input int j);
    if (high < E_MIN) m_terr = 1;
    if (rw) return;
    if (j <= m_busy_end) begin
      m_terr = 1;
      return;
    end
    if (!m_four) begin
      if (n == ((m_init_step == 3) ? 4'h2 : 4'h3)) begin
        m_busy_end = j + CMD;
        if (m_init_step == 3) m_four = 1;
        else m_init_step++;
      end else begin
        m_perr = 1;
        m_init_step = 0;
      end
    end else if (!m_have_hi) begin
      m_hi = n; m_hi_rs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      if (rs != m_hi_rs) m_perr = 1;
      model_byte(m_hi_rs, {m_hi, n}, j);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".addr"}, 32'(ddram_addr), 32'(m_addr()));
    check_output({tag, ".four_bit"}, 32'(four_bit), 32'(m_four));
    check_output({tag, ".display_on"}, 32'(display_on), 32'(m_disp));
    check_output({tag, ".cursor_on"}, 32'(cursor_on), 32'(m_cur));
    check_output({tag, ".blink_on"}, 32'(blink_on), 32'(m_blink));
    check_output({tag, ".increment"}, 32'(increment), 32'(m_inc));
    check_output({tag, ".busy"}, 32'(busy), 32'(cyc < m_busy_end));
    check_output({tag, ".timing_err"}, 32'(timing_err), 32'(m_terr));
    check_output({tag, ".proto_err"}, 32'(proto_err), 32'(m_perr));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_index = 5'(i);
      #1;
      check_output($sformatf("%s.rd_char[%0d]", tag, i), 32'(rd_char), 32'(m_mem[i]));
    end
  endtask

  task automatic check_char(input string tag, input int idx, input logic [7:0] exp);
    rd_index = 5'(idx);
    #1;
    check_output(tag, 32'(rd_char), 32'(exp));
  endtask

  task automatic send_nibble(input logic [3:0] n, input bit rs, input bit rw, input int high);
    int j;
    @(negedge clk);
    SF_D = n; LCD_RS = rs; LCD_RW = rw; LCD_E = 1'b1;
    repeat (high) @(negedge clk);
    LCD_E = 1'b0;
    SF_D = 4'($urandom);
    LCD_RS = 1'($urandom);
    j = cyc + 1;
    model_strobe(n, rs, rw, high, j);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input bit rs, input logic [7:0] b, input int high);
    send_nibble(b[7:4], rs, 1'b0, high);
    send_nibble(b[3:0], rs, 1'b0, high);
  endtask

  task automatic wait_idle();
    while (cyc < m_busy_end + 2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_init();
    logic [3:0] seq [4];
    seq[0] = 4'h3; seq[1] = 4'h3; seq[2] = 4'h3; seq[3] = 4'h2;
    for (int i = 0; i < 4; i++) begin
      send_nibble(seq[i], 1'b0, 1'b0, 12);
      wait_idle();
    end
  endtask

  initial begin
    vec_t v;
    int   kind, high;
    logic [7:0] b;

    vecs.push_back(mk(0, 8'h28, 7'h00, 0, 0, 0, 1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h06, 7'h00, 0, 0, 0, 1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h0F, 7'h00, 1, 1, 1, 1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h78, 7'h01, 1, 1, 1, 1,  0, 8'h78));
    vecs.push_back(mk(1, 8'h79, 7'h02, 1, 1, 1, 1,  1, 8'h79));
    vecs.push_back(mk(0, 8'h01, 7'h00, 1, 1, 1, 1,  0, 8'h20));
    vecs.push_back(mk(0, 8'h8E, 7'h0E, 1, 1, 1, 1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h41, 7'h0F, 1, 1, 1, 1, 14, 8'h41));
    vecs.push_back(mk(1, 8'h42, 7'h40, 1, 1, 1, 1, 15, 8'h42));
    vecs.push_back(mk(1, 8'h43, 7'h41, 1, 1, 1, 1, 16, 8'h43));
    vecs.push_back(mk(0, 8'hCF, 7'h4F, 1, 1, 1, 1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h5A, 7'h00, 1, 1, 1, 1, 31, 8'h5A));
    vecs.push_back(mk(0, 8'h04, 7'h00, 1, 1, 1, 0, -1, 8'h00));
    vecs.push_back(mk(1, 8'h71, 7'h4F, 1, 1, 1, 0,  0, 8'h71));
    vecs.push_back(mk(1, 8'h72, 7'h4E, 1, 1, 1, 0, 31, 8'h72));
    vecs.push_back(mk(0, 8'hC0, 7'h40, 1, 1, 1, 0, -1, 8'h00));
    vecs.push_back(mk(1, 8'h73, 7'h0F, 1, 1, 1, 0, 16, 8'h73));
    vecs.push_back(mk(0, 8'h0C, 7'h0F, 1, 0, 0, 0, -1, 8'h00));
    vecs.push_back(mk(0, 8'h02, 7'h00, 1, 0, 0, 0, -1, 8'h00));
    vecs.push_back(mk(0, 8'h06, 7'h00, 1, 0, 0, 1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 7'h00, 1, 0, 0, 1, -1, 8'h00));

    // Reset values
    do_reset();
    check_output("reset.addr", 32'(ddram_addr), 32'h00);
    check_output("reset.four_bit", 32'(four_bit), 32'd0);
    check_output("reset.display_on", 32'(display_on), 32'd0);
    check_output("reset.increment", 32'(increment), 32'd1);
    check_output("reset.busy", 32'(busy), 32'd0);
    check_output("reset.timing_err", 32'(timing_err), 32'd0);
    check_output("reset.proto_err", 32'(proto_err), 32'd0);
    check_mem("reset");

    // Power-on nibbles
    do_init();
    check_output("init.four_bit", 32'(four_bit), 32'd1);
    check_output("init.proto_err", 32'(proto_err), 32'd0);
    check_output("init.timing_err", 32'(timing_err), 32'd0);

    // Directed byte table
    foreach (vecs[i]) begin
      v = vecs[i];
      apply_stimulus(v.rs, v.b, 12);
      if (!v.rs && v.b == 8'h01) begin
        while (cyc < m_busy_end - 1) @(negedge clk);
        check_output("clear.busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check_output("clear.busy_done", 32'(busy), 32'd0);
        check_mem("clear");
      end
      wait_idle();
      check_output($sformatf("vec%0d.addr", i), 32'(ddram_addr), 32'(v.exp_addr));
      check_output($sformatf("vec%0d.display_on", i), 32'(display_on), 32'(v.exp_disp));
      check_output($sformatf("vec%0d.cursor_on", i), 32'(cursor_on), 32'(v.exp_cur));
      check_output($sformatf("vec%0d.blink_on", i), 32'(blink_on), 32'(v.exp_blink));
      check_output($sformatf("vec%0d.increment", i), 32'(increment), 32'(v.exp_inc));
      if (v.chk_idx >= 0)
        check_char($sformatf("vec%0d.rd_char", i), v.chk_idx, v.chk_char);
    end
    check_model("table");
    check_mem("table");

    // Byte while busy is discarded whole
    apply_stimulus(1'b1, 8'h55, 12);
    repeat (100) @(negedge clk);
    apply_stimulus(1'b1, 8'h66, 12);
    check_output("busyviol.timing_err", 32'(timing_err), 32'd1);
    check_output("busyviol.addr", 32'(ddram_addr), 32'h01);
    check_char("busyviol.rd_char1", 1, 8'h20);
    wait_idle();
    apply_stimulus(1'b1, 8'h77, 12);
    wait_idle();
    check_char("busyviol.resync", 1, 8'h77);
    check_model("busyviol");

    // Short E pulse is flagged but still processed
    do_reset();
    do_init();
    send_nibble(4'h0, 1'b0, 1'b0, 3);
    send_nibble(4'hC, 1'b0, 1'b0, 12);
    wait_idle();
    check_output("short.timing_err", 32'(timing_err), 32'd1);
    check_output("short.display_on", 32'(display_on), 32'd1);
    check_output("short.cursor_on", 32'(cursor_on), 32'd0);

    // Bad init nibble restarts the sequence without busy
    do_reset();
    send_nibble(4'h3, 1'b0, 1'b0, 12);
    wait_idle();
    send_nibble(4'h4, 1'b0, 1'b0, 12);
    check_output("badinit.proto_err", 32'(proto_err), 32'd1);
    check_output("badinit.busy", 32'(busy), 32'd0);
    send_nibble(4'h3, 1'b0, 1'b0, 12);
    wait_idle();
    send_nibble(4'h3, 1'b0, 1'b0, 12);
    wait_idle();
    send_nibble(4'h3, 1'b0, 1'b0, 12);
    wait_idle();
    check_output("badinit.four_bit_pending", 32'(four_bit), 32'd0);
    send_nibble(4'h2, 1'b0, 1'b0, 12);
    wait_idle();
    check_output("badinit.four_bit", 32'(four_bit), 32'd1);
    check_output("badinit.timing_err", 32'(timing_err), 32'd0);

    // Illegal Set DDRAM address
    do_reset();
    do_init();
    apply_stimulus(1'b0, 8'hC5, 12);
    wait_idle();
    apply_stimulus(1'b0, 8'h90, 12);
    wait_idle();
    check_output("badaddr.proto_err", 32'(proto_err), 32'd1);
    check_output("badaddr.addr", 32'(ddram_addr), 32'h45);

    // Reset in the middle of the clear sweep
    apply_stimulus(1'b0, 8'hCA, 12);
    wait_idle();
    apply_stimulus(1'b1, 8'h4B, 12);
    wait_idle();
    check_char("midclr.before", 26, 8'h4B);
    apply_stimulus(1'b0, 8'h01, 12);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_output("midclr.four_bit", 32'(four_bit), 32'd0);
    check_output("midclr.busy", 32'(busy), 32'd0);
    check_output("midclr.addr", 32'(ddram_addr), 32'h00);
    check_output("midclr.increment", 32'(increment), 32'd1);
    check_output("midclr.proto_err", 32'(proto_err), 32'd0);
    check_mem("midclr");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    do_reset();
    do_init();
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 19);
      high = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 7) : $urandom_range(8, 14);
      case (kind)
        0, 1, 2, 3, 4, 5, 6, 7: apply_stimulus(1'b1, 8'($urandom_range(32, 126)), high);
        8, 9: begin
          b = 8'($urandom_range(0, 31));
          b = (b < 8'd16) ? (8'h80 | b) : (8'hC0 | (b - 8'd16));
          apply_stimulus(1'b0, b, high);
        end
        10: apply_stimulus(1'b0, 8'h80 | 8'($urandom_range(0, 127)), high);
        11: apply_stimulus(1'b0, 8'h04 | 8'($urandom_range(0, 3)), high);
        12: apply_stimulus(1'b0, 8'h08 | 8'($urandom_range(0, 7)), high);
        13: apply_stimulus(1'b0, 8'h02 | 8'($urandom_range(0, 1)), high);
        14: apply_stimulus(1'b0, 8'h20 | 8'($urandom_range(0, 31)), high);
        15: send_nibble(4'($urandom), 1'($urandom), 1'b1, high);
        16: begin
          b = 8'h08 | 8'($urandom_range(0, 7));
          send_nibble(b[7:4], 1'b0, 1'b0, high);
          send_nibble(b[3:0], 1'b1, 1'b0, high);
        end
        17: send_nibble(4'($urandom), 1'b0, 1'b0, high);
        18: apply_stimulus(1'b0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h0E, high);
        default: apply_stimulus(1'b0, ($urandom_range(0, 1) == 0) ? 8'h00 :
                                (8'h10 | 8'($urandom_range(0, 15))), high);
      endcase
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(0, CMD + 20)) @(negedge clk);
      else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check_model($sformatf("rand%0d", n));
    end
    wait_idle();
    check_mem("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-style character-LCD responder that sits on the panel end of the 4-bit SF_D/LCD_E/LCD_RS/LCD_RW bus driven by the microprocessor's LCD driver. It decodes the power-on nibble sequence, the 4-bit instruction/data byte pairs and the 2x16 DDRAM map, and holds a 32-character shadow image. The processor side or the testbench reads that image back. Timing and protocol violations are flagged so the driver can be checked in simulation and on the board.

## Interface
- E_MIN_HIGH, 8: minimum LCD_E high width in clk cycles.
- CMD_BUSY, 1500: busy cycles after any instruction/data byte or init nibble.
- CLEAR_BUSY, 80000: busy cycles after Clear Display (0x01).

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- SF_D  in  4  [11:8], nibble DB7..DB4.
- LCD_E  in  1  enable strobe, synchronous to clk.
- LCD_RS  in  1  0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write; strobes with 1 are ignored.
- rd_index  in  5  character index 0-15 = line 1, 16-31 = line 2.
- rd_char  out  8  combinational DDRAM[rd_index].
- ddram_addr  out  7  current HD44780 address counter.
- four_bit  out  1  init sequence complete.
- display_on, cursor_on, blink_on  out  1 each  from last Display Control.
- increment  out  1  I/D bit from last Entry Mode.
- busy  out  1  busy counter non-zero.
- timing_err  out  1  sticky: short E pulse or strobe while busy.
- proto_err  out  1  sticky: bad init nibble or bad DDRAM address.

## Operation
- Strobe detect: register LCD_E into e_q. A falling edge is e_q=1 and LCD_E=0. The nibble, RS and RW are the registered values from the last high cycle. A high-width counter runs while LCD_E=1 and saturates at E_MIN_HIGH. On the fall, a count below E_MIN_HIGH sets timing_err, and the strobe is still processed.
- A falling edge with RW=1 is ignored.
- A falling edge with RW=0 while busy=1 sets timing_err, and the nibble is discarded.
- The state machine has states INIT0, INIT1, INIT2, INIT3, HI and LO.
  - INIT0, INIT1 and INIT2 each expect nibble 0x3 and then advance.
  - INIT3 expects 0x2, then sets four_bit=1 and goes to HI.
  - Each init nibble loads CMD_BUSY.
  - A wrong nibble in INIT0-3 sets proto_err, goes to INIT0 and does not load busy.
- HI latches the upper nibble and RS and goes to LO. There is no busy between nibbles.
- LO forms the byte {hi, nibble}. If RS differs from the RS latched in HI, the byte uses the HI value and proto_err is set. The byte is executed and the state returns to HI.
- Instruction decode, checked in priority order from the highest set bit:
  - 1xxxxxxx, Set DDRAM: address 0x00-0x0F or 0x40-0x4F loads ddram_addr. Any other address sets proto_err and leaves ddram_addr unchanged.
  - 001xxxxx, Function Set: accepted with no state change.
  - 00001DCB: sets display_on=D, cursor_on=C, blink_on=B.
  - 000001Ix: sets increment=I.
  - 00000001, Clear: sweeps all 32 entries to 0x20, one per cycle, during busy. Sets ddram_addr=0 and increment=1, and loads CLEAR_BUSY.
  - 0000001x, Home: sets ddram_addr=0.
  - 0x00: ignored.
  - All other instructions load CMD_BUSY.
- Data byte (RS=1): the byte is written to index (addr[6] ? 16 : 0) + addr[3:0]. The address then steps by ±1 per increment, with wrap within the 32 positions: 0x0F→0x40, 0x4F→0x00, and descending 0x00→0x4F, 0x40→0x0F. Loads CMD_BUSY.
- Index mapping: ddram_addr 0x00-0x0F → 0-15, 0x40-0x4F → 16-31.

## Timing
- Reset values: state INIT0. four_bit, display_on, cursor_on, blink_on, busy, timing_err and proto_err are 0. increment=1, ddram_addr=0, all DDRAM bytes are 0x20.
- Decoded effects (DDRAM write, register update, busy=1) are visible on the cycle after the falling-edge detect cycle.
- The busy counter loads at that edge and counts down one per cycle. busy deasserts on the cycle the counter reaches 0.
- Clear sweep takes 32 cycles inside CLEAR_BUSY. rd_char for swept entries returns 0x20 after completion.
- Deasserting rst_n mid-byte or mid-clear resets everything immediately, including the half-received nibble and the DDRAM contents.
- Error flags are sticky and cleared only by reset.

## Test plan
- Power-on sequence: nibbles 3,3,3,2, each with E high 12 cycles and gaps > CMD_BUSY → four_bit=1, proto_err=0, timing_err=0.
- Init done, then bytes 0x28, 0x06, 0x0F, 0x01 with proper waits → display_on=1, cursor_on=1, blink_on=1, increment=1. Busy lasts CLEAR_BUSY after 0x01. All rd_char = 0x20.
- Address and wrap:
  - Send 0x8E, then data 'A', 'B', 'C' → rd_char[14]=0x41, [15]=0x42, [16]=0x43, ddram_addr=0x41.
  - Then send 0xCF and 'Z' → rd_char[31]=0x5A, ddram_addr=0x00.
- Timing violations:
  - Byte sent 100 cycles after a data write → timing_err=1 and DDRAM unchanged.
  - Separately, a 3-cycle E pulse → timing_err=1.
- Protocol errors:
  - Init nibble 0x4 at INIT1 → proto_err=1, state INIT0, and a subsequent 3,3,3,2 still completes init.
  - Set DDRAM 0x90 → proto_err=1, ddram_addr unchanged.
- Reset during the clear sweep (rst_n low at sweep entry 10) → all outputs return to their reset values asynchronously, and four_bit=0.
